// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter: SRL/SRA/SLL/ROL/ROR with valid/ready flow control.
// PIPE=2 splits the log-shifter levels across two register stages.
module shift_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE = 1,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    function automatic logic [WIDTH-1:0] lvl(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       m,
        input int               s
    );
        case (m)
            3'b000:  lvl = x >> s;
            3'b001:  lvl = $signed(x) >>> s;
            3'b010:  lvl = x << s;
            3'b011:  lvl = (x << s) | (x >> (WIDTH - s));
            3'b100:  lvl = (x >> s) | (x << (WIDTH - s));
            default: lvl = x;
        endcase
    endfunction

    // Applies shifter levels hi..lo, MSB level first.
    function automatic logic [WIDTH-1:0] levels(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       m,
        input logic [SHW-1:0]   sh,
        input int               hi,
        input int               lo
    );
        logic [WIDTH-1:0] r;
        r = x;
        for (int i = hi; i >= lo; i--) begin
            if (sh[i]) r = lvl(r, m, 1 << i);
        end
        return r;
    endfunction

    logic             stall;
    logic             a_err;
    logic             fin_valid;
    logic             fin_err;
    logic [WIDTH-1:0] fin_data;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign a_err    = in_mode > 3'd4;

    generate
        if (PIPE == 2) begin : g_p2
            localparam int L1  = (SHW + 1) / 2;
            localparam int REM = SHW - L1;

            typedef struct packed {
                logic             valid;
                logic             err;
                logic [2:0]       mode;
                logic [REM-1:0]   sh;
                logic [WIDTH-1:0] data;
            } s1_t;

            s1_t s1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1 <= '0;
                end else if (!stall) begin
                    s1.valid <= in_valid;
                    s1.err   <= a_err;
                    s1.mode  <= in_mode;
                    s1.sh    <= in_shamt[REM-1:0];
                    s1.data  <= levels(in_data, in_mode, in_shamt,
                                       SHW - 1, REM);
                end
            end

            assign fin_valid = s1.valid;
            assign fin_err   = s1.err;
            assign fin_data  = levels(s1.data, s1.mode,
                                      {{L1{1'b0}}, s1.sh}, REM - 1, 0);
        end else begin : g_p1
            assign fin_valid = in_valid;
            assign fin_err   = a_err;
            assign fin_data  = levels(in_data, in_mode, in_shamt,
                                      SHW - 1, 0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
        end else if (!stall) begin
            out_valid <= fin_valid;
            out_data  <= fin_data;
            out_zero  <= (fin_data == '0);
            out_err   <= fin_err;
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed and randomized bench for shift_unit_pipe across widths and depths.
// Instances: a=32/1, b=32/2, c=8/2, d=64/1.
module tb_shift_unit_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    logic a_iv = 0, a_ir, a_ov, a_or = 1, a_oz, a_oe;
    logic [31:0] a_id = '0, a_od;
    logic [4:0] a_sh = '0;
    logic [2:0] a_m = '0;

    logic b_iv = 0, b_ir, b_ov, b_or = 1, b_oz, b_oe;
    logic [31:0] b_id = '0, b_od;
    logic [4:0] b_sh = '0;
    logic [2:0] b_m = '0;

    logic c_iv = 0, c_ir, c_ov, c_or = 1, c_oz, c_oe;
    logic [7:0] c_id = '0, c_od;
    logic [2:0] c_sh = '0;
    logic [2:0] c_m = '0;

    logic d_iv = 0, d_ir, d_ov, d_or = 1, d_oz, d_oe;
    logic [63:0] d_id = '0, d_od;
    logic [5:0] d_sh = '0;
    logic [2:0] d_m = '0;

    shift_unit_pipe #(.WIDTH(32), .PIPE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .in_shamt(a_sh), .in_mode(a_m),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .out_zero(a_oz), .out_err(a_oe));

    shift_unit_pipe #(.WIDTH(32), .PIPE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .in_shamt(b_sh), .in_mode(b_m),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .out_zero(b_oz), .out_err(b_oe));

    shift_unit_pipe #(.WIDTH(8), .PIPE(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_id), .in_shamt(c_sh), .in_mode(c_m),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .out_zero(c_oz), .out_err(c_oe));

    shift_unit_pipe #(.WIDTH(64), .PIPE(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir),
        .in_data(d_id), .in_shamt(d_sh), .in_mode(d_m),
        .out_valid(d_ov), .out_ready(d_or), .out_data(d_od),
        .out_zero(d_oz), .out_err(d_oe));

    // Bit-by-bit reference, independent of the log-shifter structure.
    function automatic logic [63:0] model(
        input logic [63:0] x, input int w, input logic [2:0] m, input int s
    );
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < w; j++) begin
            case (m)
                3'd0: r[j] = (j + s < w) ? x[j + s] : 1'b0;
                3'd1: r[j] = (j + s < w) ? x[j + s] : x[w - 1];
                3'd2: r[j] = (j >= s) ? x[j - s] : 1'b0;
                3'd3: r[j] = x[(j - s + w) % w];
                3'd4: r[j] = x[(j + s) % w];
                default: r[j] = x[j];
            endcase
        end
        return r;
    endfunction

    task automatic send_a(input logic [2:0] m, input logic [31:0] x,
                          input logic [4:0] s);
        @(negedge clk);
        a_m = m;
        a_id = x;
        a_sh = s;
        a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        total += 5;
        if (a_ov !== 1'b0) begin bad++; $display("FAIL rst_ov: got %b want 0", a_ov); end
        if (a_od !== 32'h0) begin bad++; $display("FAIL rst_od: got %h want 0", a_od); end
        if (a_oz !== 1'b0) begin bad++; $display("FAIL rst_oz: got %b want 0", a_oz); end
        if (a_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", a_oe); end
        if (b_ov !== 1'b0) begin bad++; $display("FAIL rst_b_ov: got %b want 0", b_ov); end
        rst_n = 1'b1;
        #1;
        total += 2;
        if (a_ir !== 1'b1) begin bad++; $display("FAIL rst_a_ir: got %b want 1", a_ir); end
        if (b_ir !== 1'b1) begin bad++; $display("FAIL rst_b_ir: got %b want 1", b_ir); end
    endtask

    task automatic test_vectors;
        logic [2:0]  vm [11] = '{1, 0, 3, 4, 2, 0, 2, 0, 7, 5, 4};
        logic [31:0] vx [11] = '{32'h80000000, 32'h80000000, 32'h80000001,
                                 32'h00000001, 32'h00000001, 32'hFFFFFFFF,
                                 32'h12345678, 32'h0000000F, 32'hDEADBEEF,
                                 32'h00000000, 32'hA5A5A5A5};
        logic [4:0]  vs [11] = '{4, 4, 1, 1, 31, 31, 0, 4, 5, 3, 0};
        logic [31:0] ve [11] = '{32'hF8000000, 32'h08000000, 32'h00000003,
                                 32'h80000000, 32'h80000000, 32'h00000001,
                                 32'h12345678, 32'h00000000, 32'hDEADBEEF,
                                 32'h00000000, 32'hA5A5A5A5};
        logic        vz [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        logic        vr [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 11; i++) begin
            send_a(vm[i], vx[i], vs[i]);
            total += 4;
            if (a_ov !== 1'b1) begin bad++; $display("FAIL vec%0d_valid: got %b want 1", i, a_ov); end
            if (a_od !== ve[i]) begin bad++; $display("FAIL vec%0d_data: got %h want %h", i, a_od, ve[i]); end
            if (a_oz !== vz[i]) begin bad++; $display("FAIL vec%0d_zero: got %b want %b", i, a_oz, vz[i]); end
            if (a_oe !== vr[i]) begin bad++; $display("FAIL vec%0d_err: got %b want %b", i, a_oe, vr[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [2:0]  bm [8] = '{2, 0, 1, 3, 4, 0, 2, 4};
        logic [31:0] bx [8] = '{32'h00000001, 32'h80000000, 32'h80000000,
                                32'hF0000000, 32'h0000000F, 32'h12345678,
                                32'h12345678, 32'h12345678};
        logic [4:0]  bs [8] = '{3, 8, 8, 4, 4, 17, 18, 12};
        logic [31:0] be [8] = '{32'h00000008, 32'h00800000, 32'hFF800000,
                                32'h0000000F, 32'hF0000000, 32'h0000091A,
                                32'h59E00000, 32'h67812345};
        int sent = 0;
        int got = 0;
        logic stalled = 1'b0;
        logic [31:0] held = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            b_or = !(c >= 3 && c <= 5);
            b_iv = sent < 8;
            if (sent < 8) begin
                b_m = bm[sent];
                b_id = bx[sent];
                b_sh = bs[sent];
            end
            #1;
            if (stalled) begin
                total++;
                if (b_od !== held) begin bad++; $display("FAIL b2b_hold c%0d: got %h want %h", c, b_od, held); end
            end
            total++;
            if (b_ir !== !(b_ov && !b_or)) begin
                bad++;
                $display("FAIL b2b_ready c%0d: got %b want %b", c, b_ir, !(b_ov && !b_or));
            end
            if (b_ov && b_or) begin
                total++;
                if (b_od !== be[got]) begin bad++; $display("FAIL b2b_res%0d: got %h want %h", got, b_od, be[got]); end
                got++;
            end
            if (b_iv && b_ir) sent++;
            stalled = b_ov && !b_or;
            held = b_od;
        end
        b_iv = 1'b0;
        b_or = 1'b1;
        total++;
        if (got != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got); end
        @(negedge clk);
    endtask

    task automatic test_reset_flight;
        @(negedge clk);
        b_m = 3'd2; b_id = 32'h1; b_sh = 5'd1; b_iv = 1'b1;
        a_m = 3'd2; a_id = 32'h1; a_sh = 5'd2; a_iv = 1'b1;
        @(negedge clk);
        b_id = 32'h2;
        a_id = 32'h2;
        @(negedge clk);
        b_iv = 1'b0;
        a_iv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (b_ov !== 1'b0) begin bad++; $display("FAIL flight_b_ov: got %b want 0", b_ov); end
        if (b_od !== 32'h0) begin bad++; $display("FAIL flight_b_od: got %h want 0", b_od); end
        if (a_ov !== 1'b0) begin bad++; $display("FAIL flight_a_ov: got %b want 0", a_ov); end
        @(negedge clk);
        rst_n = 1'b1;
        a_m = 3'd1; a_id = 32'hF0000000; a_sh = 5'd8; a_iv = 1'b1;
        #1;
        total++;
        if (a_ir !== 1'b1) begin bad++; $display("FAIL flight_a_ir: got %b want 1", a_ir); end
        @(negedge clk);
        a_iv = 1'b0;
        total += 3;
        if (a_ov !== 1'b1) begin bad++; $display("FAIL first_acc_valid: got %b want 1", a_ov); end
        if (a_od !== 32'hFFF00000) begin bad++; $display("FAIL first_acc_data: got %h want fff00000", a_od); end
        if (b_ov !== 1'b0) begin bad++; $display("FAIL stale_b0: got %b want 0", b_ov); end
        @(negedge clk);
        total++;
        if (b_ov !== 1'b0) begin bad++; $display("FAIL stale_b1: got %b want 0", b_ov); end
        b_m = 3'd3; b_id = 32'h80000001; b_sh = 5'd3; b_iv = 1'b1;
        @(negedge clk);
        b_iv = 1'b0;
        total++;
        if (b_ov !== 1'b0) begin bad++; $display("FAIL post_lat1: got %b want 0", b_ov); end
        @(negedge clk);
        total += 2;
        if (b_ov !== 1'b1) begin bad++; $display("FAIL post_lat2: got %b want 1", b_ov); end
        if (b_od !== 32'h0000000C) begin bad++; $display("FAIL post_data: got %h want 0000000c", b_od); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [63:0] qc [$];
        logic [63:0] qd [$];
        logic ec [$];
        logic ed [$];
        logic [63:0] w;
        logic e;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            c_or = $urandom_range(0, 3) != 0;
            d_or = $urandom_range(0, 3) != 0;
            c_iv = cyc < 440 && $urandom_range(0, 3) != 0;
            d_iv = cyc < 440 && $urandom_range(0, 3) != 0;
            c_id = 8'($urandom);
            d_id = {$urandom, $urandom};
            c_sh = 3'($urandom_range(0, 7));
            d_sh = 6'($urandom_range(0, 63));
            c_m = ($urandom_range(0, 9) == 0) ? 3'd6 : 3'($urandom_range(0, 4));
            d_m = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 4));
            #1;
            if (c_ov && c_or) begin
                total++;
                if (qc.size() == 0) begin
                    bad++;
                    $display("FAIL rnd8_extra: got %h want none", c_od);
                end else begin
                    w = qc.pop_front();
                    e = ec.pop_front();
                    if (c_od !== w[7:0] || c_oe !== e || c_oz !== (w == 0)) begin
                        bad++;
                        $display("FAIL rnd8: got %h/%b want %h/%b", c_od, c_oe, w[7:0], e);
                    end
                end
            end
            if (d_ov && d_or) begin
                total++;
                if (qd.size() == 0) begin
                    bad++;
                    $display("FAIL rnd64_extra: got %h want none", d_od);
                end else begin
                    w = qd.pop_front();
                    e = ed.pop_front();
                    if (d_od !== w || d_oe !== e || d_oz !== (w == 0)) begin
                        bad++;
                        $display("FAIL rnd64: got %h/%b want %h/%b", d_od, d_oe, w, e);
                    end
                end
            end
            if (c_iv && c_ir) begin
                qc.push_back(model({56'h0, c_id}, 8, c_m, int'(c_sh)));
                ec.push_back(c_m > 3'd4);
            end
            if (d_iv && d_ir) begin
                qd.push_back(model(d_id, 64, d_m, int'(d_sh)));
                ed.push_back(d_m > 3'd4);
            end
        end
        c_iv = 1'b0;
        d_iv = 1'b0;
        total += 2;
        if (qc.size() != 0) begin bad++; $display("FAIL rnd8_left: got %0d want 0", qc.size()); end
        if (qd.size() != 0) begin bad++; $display("FAIL rnd64_left: got %0d want 0", qd.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_flight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
SHIFT_UNIT_PIPE -- requirements
Module: shift_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter PIPE, default 1: pipeline depth in cycles; legal values 1 or 2.
REQ-003 SHALL derive local SHW = log2(WIDTH), the shift-amount width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port in_shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-010 SHALL have port in_mode  input  3  000 SRL, 001 SRA, 010 SLL, 011 ROL, 100 ROR, others illegal.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-013 SHALL have port out_data  output  WIDTH  result.
REQ-014 SHALL have port out_zero  output  1  out_data == 0.
REQ-015 SHALL have port out_err  output  1  request carried an illegal in_mode.

Function
REQ-016 SHALL implement a log-shifter: SHW levels shifting by 2^(SHW-1) down to 1, each level controlled by one in_shamt bit, MSB level first.
REQ-017 SRL SHALL zero-fill from the MSB; SRA SHALL fill with in_data[WIDTH-1]; SLL SHALL zero-fill from the LSB.
REQ-018 ROL/ROR SHALL rotate, with bits leaving one end re-entering the other.
REQ-019 in_shamt = 0 SHALL return in_data unchanged in every legal mode.
REQ-020 An illegal in_mode SHALL return in_data unchanged with out_err = 1; a legal mode SHALL give out_err = 0.
REQ-021 out_zero and out_err SHALL be registered with out_data and travel with the same request.
REQ-022 PIPE=1: a single output register; a result SHALL be valid one cycle after acceptance.
REQ-023 PIPE=2: an extra register after the first ceil(SHW/2) levels, carrying partial data, remaining shamt bits, mode and err; a result SHALL be valid two cycles after acceptance.
REQ-024 Every pipeline stage SHALL carry its own valid bit.
REQ-025 Pipeline stall condition: stall = out_valid && !out_ready.
REQ-026 On stall, every stage SHALL hold its contents, and out_data/out_zero/out_err SHALL stay stable.
REQ-027 in_ready SHALL equal !stall, combinationally; no request SHALL be lost or duplicated.
REQ-028 With no stall, a new request SHALL be accepted every cycle, giving throughput of one result per cycle.
REQ-029 Bubbles (in_valid = 0) SHALL propagate as invalid stages; data in an invalid stage is don't-care.
REQ-030 Simultaneous output consume and input accept in the same cycle SHALL be legal: the pipe advances by one.
REQ-031 out_data SHALL be driven only from the output register; no combinational path from in_* to out_*.

Reset
REQ-032 While rst_n = 0, all stage valids, out_valid, out_zero and out_err SHALL be 0 and out_data SHALL be 0, asynchronously.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight requests.
REQ-034 The first acceptance SHALL be possible on the first rising clk edge after rst_n deasserts.
REQ-035 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-036 WIDTH=32, PIPE=1: SRA 0x80000000 by 4 -> 0xF8000000 one cycle later; SRL same operand -> 0x08000000.
REQ-037 ROL 0x80000001 by 1 -> 0x00000003; ROR 0x00000001 by 1 -> 0x80000000; SLL 0x00000001 by 31 -> 0x80000000; SRL 0xFFFFFFFF by 31 -> 0x00000001.
REQ-038 SLL 0x12345678 by 0 -> 0x12345678 with out_zero=0; SRL 0x0000000F by 4 -> 0 with out_zero=1; mode 111 on 0xDEADBEEF -> 0xDEADBEEF with out_err=1.
REQ-039 PIPE=2, back-to-back stream of 8 requests, out_ready low for cycles 3-5: in_ready low during the stall, out_data held, all 8 results in order with none dropped.
REQ-040 Reset pulse while 2 requests are in flight: out_valid=0 immediately; no stale result after release; the next request returns the correct value after PIPE cycles.
REQ-041 WIDTH=8 and WIDTH=64 random regression of modes and shamt against a software reference model, with random backpressure and zero mismatches.
